// File: rtl/am_if_modulator.sv
// Synthetic full-carrier AM IF source: NCO sine carrier scaled by (128 + audio),
// with a one-entry audio buffer drained at a fixed sample rate.
module am_if_modulator #(
  parameter int PHASE_W = 16,
  parameter int DIV     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [7:0]         env_in,
  input  logic               env_valid,
  output logic               env_ready,
  output logic [5:0]         ifreq,
  output logic               underrun
);
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               env_ready_q, env_ready_d;
  logic [7:0]         env_q, env_d;
  logic [5:0]         sine_q, sine_d;
  logic [7:0]         env1_q, env1_d;
  logic [5:0]         ifreq_q, ifreq_d;
  logic               underrun_q, underrun_d;

  logic               strobe;
  logic               xfer;
  logic [1:0]         quad;
  logic [2:0]         lut_idx;
  logic [4:0]         mag;
  logic [5:0]         sine_val;
  logic signed [14:0] s_ext, e_ext, prod, rounded;

  // Quarter-wave table; odd quadrants read it mirrored (7-i == ~i).
  always_comb begin
    quad    = phase_q[PHASE_W-1 -: 2];
    lut_idx = quad[0] ? ~phase_q[PHASE_W-3 -: 3] : phase_q[PHASE_W-3 -: 3];
    case (lut_idx)
      3'd0:    mag = 5'd3;
      3'd1:    mag = 5'd9;
      3'd2:    mag = 5'd15;
      3'd3:    mag = 5'd20;
      3'd4:    mag = 5'd24;
      3'd5:    mag = 5'd27;
      3'd6:    mag = 5'd30;
      default: mag = 5'd31;
    endcase
    sine_val = quad[1] ? -{1'b0, mag} : {1'b0, mag};
  end

  always_comb begin
    strobe   = en && (cnt_q == CNT_LAST);
    xfer     = env_valid && env_ready_q;

    phase_d  = en ? phase_q + ftw : phase_q;

    cnt_d    = cnt_q;
    if (en) cnt_d = strobe ? '0 : cnt_q + CNT_W'(1);

    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    env_d      = env_q;
    if (xfer) begin
      buf_d      = env_in;
      buf_full_d = 1'b1;
    end else if (strobe && buf_full_q) begin
      // Offset-binary conversion: signed audio plus 128.
      env_d      = {~buf_q[7], buf_q[6:0]};
      buf_full_d = 1'b0;
    end
    env_ready_d = !buf_full_d;
    underrun_d  = strobe && !buf_full_q;

    sine_d  = en ? sine_val : 6'd0;
    env1_d  = env_q;

    s_ext   = {{9{sine_q[5]}}, sine_q};
    e_ext   = {7'd0, env1_q};
    prod    = s_ext * e_ext;
    rounded = prod + 15'sd128;
    ifreq_d = 6'(rounded >>> 8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      env_ready_q <= 1'b1;
      env_q       <= 8'd128;
      sine_q      <= '0;
      env1_q      <= 8'd128;
      ifreq_q     <= '0;
      underrun_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      env_ready_q <= env_ready_d;
      env_q       <= env_d;
      sine_q      <= sine_d;
      env1_q      <= env1_d;
      ifreq_q     <= ifreq_d;
      underrun_q  <= underrun_d;
    end
  end

  assign env_ready = env_ready_q;
  assign ifreq     = ifreq_q;
  assign underrun  = underrun_q;

endmodule
